screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Sequences screen changes requested by the main screen state machine. It fades the picture out frame by frame, commits the new screen to the drawing datapath while the picture is black, then fades back in. It sits between the main screen state machine's `state_bin` output and the per-screen renderers and RGB scaler. Its `screen_sel` replaces `state_bin` as the select for the draw modules.

## Interface
Parameters:
- `FRAMES_PER_STEP`, default 2: frame ticks per brightness step. Legal range is 1..15.

Ports:
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `state_bin`  in  4  requested screen, one-hot:
  - 4'b0001 start.
  - 4'b0010 game.
  - 4'b0100 end.
- `frame_tick`  in  1  one-cycle pulse per frame, at vblank start.
- `screen_sel`  out  4  committed screen, one-hot, same encoding as `state_bin`.
- `brightness`  out  4  fade level for the RGB scaler. 15 is full, 0 is black.
- `busy`  out  1  high whenever the state is not IDLE.
- `game_rst`  out  1  one-cycle pulse when the game screen is committed.
- `done`  out  1  one-cycle pulse when a transition completes.

## Operation
- Valid request: `state_bin` is one of 0001, 0010 or 0100. All other codes are ignored in every state.
- Pending request: a valid request that differs from `screen_sel` (in IDLE) or from `target` (in FADE_OUT).
- Internal registers:
  - `target[3:0]`.
  - `step_cnt[3:0]`, which counts `frame_tick`s.
- IDLE:
  - `brightness` = 15.
  - A pending request latches `target` <= `state_bin`, clears `step_cnt` and moves to FADE_OUT.
- FADE_OUT:
  - Each `frame_tick` increments `step_cnt`.
  - When the tick makes `step_cnt` reach FRAMES_PER_STEP: `step_cnt` <= 0 and `brightness` <= `brightness` - 1.
  - When `brightness` becomes 0 in that update, move to SWAP next cycle.
  - Retarget: a valid request different from both `target` and `screen_sel` updates `target`. Fading continues without restart.
  - Abort: a valid request equal to `screen_sel` moves to FADE_IN without SWAP. `brightness` keeps its current value and `step_cnt` is cleared. No `game_rst` is issued.
- SWAP, exactly one cycle:
  - `screen_sel` <= `target`.
  - `game_rst` is pulsed if `target` = 0010.
  - `frame_tick` is not counted.
  - Clear `step_cnt` and move to FADE_IN.
- FADE_IN:
  - Each `frame_tick` counts toward a step, as in FADE_OUT.
  - At each step `brightness` <= `brightness` + 1.
  - When it becomes 15, move to IDLE and pulse `done`.
  - Requests are ignored in FADE_IN. They are re-evaluated in IDLE on the first IDLE cycle.
- `brightness` saturates: never below 0, never above 15. There is no wrap-around.

## Timing
- Reset (async assert, sync release):
  - state IDLE, `screen_sel` = 4'b0001, `brightness` = 15.
  - `busy`, `game_rst` and `done` = 0.
  - `target` = 4'b0001, `step_cnt` = 0.
- All outputs are registered.
- Request sampled in IDLE at cycle t gives `busy` = 1 at t+1.
- A `brightness` update is visible the cycle after the qualifying `frame_tick`.
- Full fade-out takes 15·FRAMES_PER_STEP ticks. Full fade-in takes the same.
- SWAP occupies one cycle after `brightness` reaches 0.
- `screen_sel` and `game_rst` change or assert in the cycle after SWAP. This is the same cycle the state reads FADE_IN.
- `done` and `busy` = 0 assert in the same cycle the state reads IDLE, one cycle after the final tick.
- Reset mid-transition returns immediately to the reset values, including `brightness` = 15.

## Test plan
- Reset, then `state_bin` = 0001 held, FRAMES_PER_STEP = 2: `screen_sel` = 0001, `brightness` = 15, `busy` = 0 indefinitely, and no pulses.
- `state_bin` 0001→0010:
  - `brightness` steps 15→0 over 30 ticks.
  - SWAP follows; then `screen_sel` = 0010 and `game_rst` is pulsed exactly once.
  - `brightness` steps 0→15 over 30 ticks.
  - `done` is pulsed once and `busy` falls.
- From game, request 0100 mid-fade-out at `brightness` = 8, then request 0001 at `brightness` = 5:
  - Fade continues uninterrupted.
  - `screen_sel` ends 0001.
  - No `game_rst` is issued.
- Abort: from 0001, request 0010, then return `state_bin` to 0001 at `brightness` = 10:
  - Fade-in from 10 to 15 over 10 ticks.
  - `screen_sel` stays 0001, no `game_rst`, and `done` is pulsed.
- Invalid codes 0000, 0011 and 1000 in IDLE and FADE_OUT: no state change and no retarget.
- Assert `rst_n` = 0 mid-fade-in at `brightness` = 7: outputs asynchronously return to reset values. After release the block is IDLE with `screen_sel` = 0001.

Source files
------------

// File: rtl/screen_sequencer.sv
// Screen-change sequencer: fades the picture to black, commits the requested
// screen to the draw datapath, then fades back in.
module screen_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state_bin,
    input  logic       frame_tick,
    output logic [3:0] screen_sel,
    output logic [3:0] brightness,
    output logic       busy,
    output logic       game_rst,
    output logic       done
);

    localparam logic [3:0] SCR_START   = 4'b0001;
    localparam logic [3:0] SCR_GAME    = 4'b0010;
    localparam logic [3:0] SCR_END     = 4'b0100;
    localparam logic [3:0] BRIGHT_FULL = 4'd15;
    localparam logic [3:0] STEP_LAST   = 4'(FRAMES_PER_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FADE_OUT,
        S_SWAP,
        S_FADE_IN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] target_q, target_d;
    logic [3:0] step_cnt_q, step_cnt_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] bright_q, bright_d;
    logic       busy_q, busy_d;
    logic       game_rst_q, game_rst_d;
    logic       done_q, done_d;

    logic       req_valid;
    logic [3:0] cnt_inc;
    logic       step_hit;
    logic [3:0] cnt_adv;
    logic [3:0] bright_dn;
    logic [3:0] bright_up;

    always_comb begin
        req_valid = (state_bin == SCR_START) || (state_bin == SCR_GAME) ||
                    (state_bin == SCR_END);
        cnt_inc   = step_cnt_q + 4'd1;
        step_hit  = frame_tick && (cnt_inc == STEP_LAST);
        if (!frame_tick) begin
            cnt_adv = step_cnt_q;
        end else if (step_hit) begin
            cnt_adv = '0;
        end else begin
            cnt_adv = cnt_inc;
        end
        bright_dn = (bright_q == '0) ? '0 : bright_q - 4'd1;
        bright_up = (bright_q == BRIGHT_FULL) ? BRIGHT_FULL : bright_q + 4'd1;
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        step_cnt_d = step_cnt_q;
        sel_d      = sel_q;
        bright_d   = bright_q;
        game_rst_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                bright_d = BRIGHT_FULL;
                if (req_valid && (state_bin != sel_q)) begin
                    target_d   = state_bin;
                    step_cnt_d = '0;
                    state_d    = S_FADE_OUT;
                end
            end
            S_FADE_OUT: begin
                // Asking for the screen already shown reverses the fade in place.
                if (req_valid && (state_bin == sel_q)) begin
                    step_cnt_d = '0;
                    state_d    = S_FADE_IN;
                end else begin
                    if (req_valid) begin
                        target_d = state_bin;
                    end
                    step_cnt_d = cnt_adv;
                    if (step_hit) begin
                        bright_d = bright_dn;
                        if (bright_dn == '0) begin
                            state_d = S_SWAP;
                        end
                    end
                end
            end
            S_SWAP: begin
                sel_d      = target_q;
                game_rst_d = (target_q == SCR_GAME);
                step_cnt_d = '0;
                state_d    = S_FADE_IN;
            end
            S_FADE_IN: begin
                step_cnt_d = cnt_adv;
                if (step_hit) begin
                    bright_d = bright_up;
                    if (bright_up == BRIGHT_FULL) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            target_q   <= SCR_START;
            step_cnt_q <= '0;
            sel_q      <= SCR_START;
            bright_q   <= BRIGHT_FULL;
            busy_q     <= 1'b0;
            game_rst_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            step_cnt_q <= step_cnt_d;
            sel_q      <= sel_d;
            bright_q   <= bright_d;
            busy_q     <= busy_d;
            game_rst_q <= game_rst_d;
            done_q     <= done_d;
        end
    end

    assign screen_sel = sel_q;
    assign brightness = bright_q;
    assign busy       = busy_q;
    assign game_rst   = game_rst_q;
    assign done       = done_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: a per-cycle behavioural model plus
// hand-computed checkpoints for each transition scenario.
module tb_screen_sequencer;

    localparam int unsigned FPS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] state_bin = 4'b0001;
    logic       frame_tick = 1'b0;
    logic [3:0] screen_sel;
    logic [3:0] brightness;
    logic       busy;
    logic       game_rst;
    logic       done;

    int n_vec = 0;
    int n_err = 0;
    int gr_cnt = 0;
    int done_cnt = 0;
    int tick_n = 0;

    screen_sequencer #(.FRAMES_PER_STEP(FPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state_bin (state_bin),
        .frame_tick(frame_tick),
        .screen_sel(screen_sel),
        .brightness(brightness),
        .busy      (busy),
        .game_rst  (game_rst),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Model phases: 0 idle, 1 darkening, 2 commit, 3 brightening.
    int         m_ph = 0;
    int         m_frames = 0;
    int         m_bri = 15;
    logic [3:0] m_sel = 4'b0001;
    logic [3:0] m_tgt = 4'b0001;
    logic       m_gr = 1'b0;
    logic       m_done = 1'b0;

    function automatic bit is_valid(input logic [3:0] c);
        return (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0100);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_frames = 0; m_bri = 15;
            m_sel = 4'b0001; m_tgt = 4'b0001; m_gr = 1'b0; m_done = 1'b0;
        end else begin
            m_gr = 1'b0;
            m_done = 1'b0;
            if (m_ph == 0) begin
                m_bri = 15;
                if (is_valid(state_bin) && state_bin != m_sel) begin
                    m_tgt = state_bin; m_frames = 0; m_ph = 1;
                end
            end else if (m_ph == 1) begin
                if (is_valid(state_bin) && state_bin == m_sel) begin
                    m_frames = 0; m_ph = 3;
                end else begin
                    if (is_valid(state_bin)) m_tgt = state_bin;
                    if (frame_tick) begin
                        m_frames++;
                        if (m_frames == int'(FPS)) begin
                            m_frames = 0;
                            m_bri = (m_bri > 0) ? m_bri - 1 : 0;
                            if (m_bri == 0) m_ph = 2;
                        end
                    end
                end
            end else if (m_ph == 2) begin
                m_sel = m_tgt;
                m_gr = (m_tgt == 4'b0010);
                m_frames = 0;
                m_ph = 3;
            end else begin
                if (frame_tick) begin
                    m_frames++;
                    if (m_frames == int'(FPS)) begin
                        m_frames = 0;
                        m_bri = (m_bri < 15) ? m_bri + 1 : 15;
                        if (m_bri == 15) begin
                            m_ph = 0; m_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        n_vec++;
        if (screen_sel !== m_sel || brightness !== 4'(m_bri) || busy !== (m_ph != 0) ||
            game_rst !== m_gr || done !== m_done) begin
            n_err++;
            $display("FAIL cycle_outputs @%0t: got sel=%b bri=%0d busy=%b grst=%b done=%b, expected sel=%b bri=%0d busy=%b grst=%b done=%b",
                     $time, screen_sel, brightness, busy, game_rst, done,
                     m_sel, m_bri, (m_ph != 0), m_gr, m_done);
        end
        if (game_rst === 1'b1) gr_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick_n++;
    endtask

    task automatic tick_until(input int b, input string nm);
        int guard = 0;
        while (brightness != 4'(b) && guard < 100) begin
            tick();
            guard++;
        end
        chk(nm, int'(brightness), b);
    endtask

    task automatic wait_idle(input string nm);
        int guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        chk(nm, int'(busy), 0);
    endtask

    logic [3:0] bad_codes [3] = '{4'b0000, 4'b0011, 4'b1000};
    int t0, gr0, d0;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_sel", int'(screen_sel), 1);
        chk("reset_bri", int'(brightness), 15);
        rst_n = 1'b1;

        // Idle with the current screen requested: nothing moves.
        repeat (4) tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_bri", int'(brightness), 15);
        chk("idle_no_pulses", gr_cnt + done_cnt, 0);

        // start -> game
        @(negedge clk) state_bin = 4'b0010;
        @(posedge clk) #1 chk("busy_next_cycle", int'(busy), 1);
        t0 = tick_n;
        tick(); tick();
        chk("first_step_bri", int'(brightness), 14);
        tick_until(0, "fade_out_black");
        chk("fade_out_ticks", tick_n - t0, 30);
        wait_idle("game_idle");
        chk("game_total_ticks", tick_n - t0, 60);
        chk("game_sel", int'(screen_sel), 2);
        chk("game_rst_once", gr_cnt, 1);
        chk("game_done_once", done_cnt, 1);

        // Retargets during fade-out: game -> (start, end, start)
        gr0 = gr_cnt; d0 = done_cnt; t0 = tick_n;
        @(negedge clk) state_bin = 4'b0001;
        tick_until(8, "retarget_at_8");
        state_bin = 4'b0100;
        tick_until(5, "retarget_at_5");
        state_bin = 4'b0001;
        wait_idle("retarget_idle");
        chk("retarget_total_ticks", tick_n - t0, 60);
        chk("retarget_sel", int'(screen_sel), 1);
        chk("retarget_no_grst", gr_cnt - gr0, 0);
        chk("retarget_done", done_cnt - d0, 1);

        // Abort at brightness 10
        gr0 = gr_cnt; d0 = done_cnt;
        @(negedge clk) state_bin = 4'b0010;
        tick_until(10, "abort_at_10");
        state_bin = 4'b0001;
        t0 = tick_n;
        wait_idle("abort_idle");
        chk("abort_fade_in_ticks", tick_n - t0, 10);
        chk("abort_sel", int'(screen_sel), 1);
        chk("abort_no_grst", gr_cnt - gr0, 0);
        chk("abort_done", done_cnt - d0, 1);

        // Invalid codes in IDLE, then during fade-out
        foreach (bad_codes[i]) begin
            @(negedge clk) state_bin = bad_codes[i];
            tick(); tick();
            chk("invalid_idle_busy", int'(busy), 0);
        end
        gr0 = gr_cnt; t0 = tick_n;
        @(negedge clk) state_bin = 4'b0010;
        tick_until(12, "invalid_fade_at_12");
        foreach (bad_codes[i]) begin
            state_bin = bad_codes[i];
            tick();
        end
        wait_idle("invalid_fade_idle");
        chk("invalid_fade_ticks", tick_n - t0, 60);
        chk("invalid_fade_sel", int'(screen_sel), 2);
        chk("invalid_fade_grst", gr_cnt - gr0, 1);

        // Reset in the middle of fade-in toward the end screen
        @(negedge clk) state_bin = 4'b0100;
        tick_until(0, "rst_scn_black");
        tick_until(7, "rst_scn_at_7");
        chk("rst_scn_sel_before", int'(screen_sel), 4);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", int'(screen_sel), 1);
        chk("async_rst_bri", int'(brightness), 15);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_pulses", int'(game_rst) + int'(done), 0);
        state_bin = 4'b0001;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_sel", int'(screen_sel), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
